// File: rtl/fu_pkg.sv
// Shared definitions for the function-unit request arbiter: FS codes,
// FS legality check, arbiter state encoding and response flag bit positions.
package fu_pkg;

  localparam logic [4:0] FS_MOVA  = 5'b00000;
  localparam logic [4:0] FS_ADD   = 5'b00010;
  localparam logic [4:0] FS_SUB   = 5'b00101;
  localparam logic [4:0] FS_MOVA2 = 5'b00111;
  localparam logic [4:0] FS_AND   = 5'b01000;
  localparam logic [4:0] FS_OR    = 5'b01010;
  localparam logic [4:0] FS_XOR   = 5'b01100;
  localparam logic [4:0] FS_NOT   = 5'b01110;
  localparam logic [4:0] FS_SHL   = 5'b10000;
  localparam logic [4:0] FS_SHR   = 5'b10001;

  // Bit positions inside rsp_flags = {Z,C,N,V}
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  // True for every FS code the function unit implements.
  function automatic logic fs_legal(input logic [4:0] fs);
    case (fs)
      FS_MOVA, FS_ADD, FS_SUB, FS_MOVA2, FS_AND,
      FS_OR, FS_XOR, FS_NOT, FS_SHL, FS_SHR: fs_legal = 1'b1;
      default:                               fs_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fu_rr_grant.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to prio.
module fu_rr_grant (
  input  logic [1:0] req_valid,
  input  logic       prio,
  output logic       any,
  output logic       grant
);

  // Pick the winning port index from the valid vector and priority pointer.
  always_comb begin
    any   = |req_valid;
    grant = 1'b0;
    case (req_valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = prio;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/fu_request_arbiter.sv
// Shares one combinational function unit between two requesters. Winner's
// fields are registered onto fu_*, results are sampled after a settle delay
// and returned as a tagged response; one operation in flight at a time.
module fu_request_arbiter
  import fu_pkg::*;
#(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [4:0]        req0_sh,
  input  logic [4:0]        req0_fs,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [4:0]        req1_sh,
  input  logic [4:0]        req1_fs,
  output logic              fu_reset,
  output logic [DATA_W-1:0] fu_a,
  output logic [DATA_W-1:0] fu_b,
  output logic [4:0]        fu_sh,
  output logic [4:0]        fu_fs,
  input  logic [DATA_W-1:0] fu_f,
  input  logic              fu_z,
  input  logic              fu_c,
  input  logic              fu_n,
  input  logic              fu_v,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_f,
  output logic [3:0]        rsp_flags,
  output logic              rsp_err
);

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  arb_state_t        state;
  arb_state_t        state_next;
  logic              prio;
  logic [3:0]        cnt;
  logic              owner;
  logic              grant_any;
  logic              grant_idx;
  logic              accept;
  logic              sel_legal;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [4:0]        sel_sh;
  logic [4:0]        sel_fs;

  fu_rr_grant u_grant (
    .req_valid (req_valid),
    .prio      (prio),
    .any       (grant_any),
    .grant     (grant_idx)
  );

  assign fu_reset  = RESET;
  assign rsp_valid = (state == RESP);

  // Route the winning port's fields and classify its FS code.
  always_comb begin
    sel_a     = grant_idx ? req1_a  : req0_a;
    sel_b     = grant_idx ? req1_b  : req0_b;
    sel_sh    = grant_idx ? req1_sh : req0_sh;
    sel_fs    = grant_idx ? req1_fs : req0_fs;
    sel_legal = fs_legal(sel_fs);
  end

  // Ready only to the winner and only while idle; accept is the handshake.
  always_comb begin
    req_ready = '0;
    if ((state == IDLE) && grant_any) begin
      req_ready[grant_idx] = 1'b1;
    end
    accept = |(req_valid & req_ready);
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = sel_legal ? SETTLE : RESP;
      SETTLE:  if (cnt == '0) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operand latch, settle counter, priority pointer and response capture.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      prio      <= 1'b0;
      cnt       <= '0;
      owner     <= 1'b0;
      fu_a      <= '0;
      fu_b      <= '0;
      fu_sh     <= '0;
      fu_fs     <= '0;
      rsp_id    <= 1'b0;
      rsp_f     <= '0;
      rsp_flags <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            prio  <= ~grant_idx;
            owner <= grant_idx;
            if (sel_legal) begin
              fu_a  <= sel_a;
              fu_b  <= sel_b;
              fu_sh <= sel_sh;
              fu_fs <= sel_fs;
              cnt   <= CNT_LOAD;
            end else begin
              rsp_err   <= 1'b1;
              rsp_f     <= '0;
              rsp_flags <= '0;
              rsp_id    <= grant_idx;
            end
          end
        end
        SETTLE: begin
          if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rsp_f             <= fu_f;
            rsp_flags[FLAG_Z] <= fu_z;
            rsp_flags[FLAG_C] <= fu_c;
            rsp_flags[FLAG_N] <= fu_n;
            rsp_flags[FLAG_V] <= fu_v;
            rsp_err           <= 1'b0;
            rsp_id            <= owner;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fu_request_arbiter.sv
// Directed bench for fu_request_arbiter with a behavioural function unit.
// Two instances: SETTLE_CYCLES=1 and SETTLE_CYCLES=3; sel picks which one
// receives handshakes and is observed.
module tb_fu_request_arbiter;
  import fu_pkg::*;

  localparam int unsigned W = 32;

  typedef struct {
    logic         id;
    logic [W-1:0] f;
    logic [3:0]   flags;
    logic         err;
  } exp_t;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic sel = 1'b0;

  always #5 CLK = ~CLK;

  logic [1:0]   req_valid = '0;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [4:0]   req0_sh = '0, req0_fs = '0, req1_sh = '0, req1_fs = '0;

  // Per-instance signals
  logic [1:0]   d1_req_valid, d3_req_valid, d1_req_ready, d3_req_ready;
  logic         d1_rsp_ready, d3_rsp_ready;
  logic         d1_fu_reset, d3_fu_reset;
  logic [W-1:0] d1_fu_a, d1_fu_b, d3_fu_a, d3_fu_b, d1_fu_f, d3_fu_f;
  logic [4:0]   d1_fu_sh, d1_fu_fs, d3_fu_sh, d3_fu_fs;
  logic         d1_fu_z, d1_fu_c, d1_fu_n, d1_fu_v;
  logic         d3_fu_z, d3_fu_c, d3_fu_n, d3_fu_v;
  logic         d1_rsp_valid, d3_rsp_valid, d1_rsp_id, d3_rsp_id;
  logic         d1_rsp_err, d3_rsp_err;
  logic [W-1:0] d1_rsp_f, d3_rsp_f;
  logic [3:0]   d1_rsp_flags, d3_rsp_flags;

  // Observed (selected) outputs
  logic [1:0]   req_ready;
  logic         fu_reset, rsp_valid, rsp_id, rsp_err;
  logic [W-1:0] fu_a, fu_b, rsp_f;
  logic [4:0]   fu_sh, fu_fs;
  logic [3:0]   rsp_flags;

  assign d1_req_valid = sel ? 2'b00 : req_valid;
  assign d3_req_valid = sel ? req_valid : 2'b00;
  assign d1_rsp_ready = sel ? 1'b0 : rsp_ready;
  assign d3_rsp_ready = sel ? rsp_ready : 1'b0;

  assign req_ready = sel ? d3_req_ready : d1_req_ready;
  assign fu_reset  = sel ? d3_fu_reset  : d1_fu_reset;
  assign fu_a      = sel ? d3_fu_a      : d1_fu_a;
  assign fu_b      = sel ? d3_fu_b      : d1_fu_b;
  assign fu_sh     = sel ? d3_fu_sh     : d1_fu_sh;
  assign fu_fs     = sel ? d3_fu_fs     : d1_fu_fs;
  assign rsp_valid = sel ? d3_rsp_valid : d1_rsp_valid;
  assign rsp_id    = sel ? d3_rsp_id    : d1_rsp_id;
  assign rsp_f     = sel ? d3_rsp_f     : d1_rsp_f;
  assign rsp_flags = sel ? d3_rsp_flags : d1_rsp_flags;
  assign rsp_err   = sel ? d3_rsp_err   : d1_rsp_err;

  // Behavioural function unit: returns {Z,C,N,V,F}.
  function automatic logic [W+3:0] fu_eval(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [4:0] sh, input logic [4:0] fs);
    logic [W:0]   s;
    logic [W-1:0] f;
    logic         c, v;
    s = '0; f = '0; c = 1'b0; v = 1'b0;
    case (fs)
      FS_MOVA, FS_MOVA2: f = a;
      FS_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        f = s[W-1:0]; c = s[W];
        v = (a[W-1] == b[W-1]) && (f[W-1] != a[W-1]);
      end
      FS_SUB: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        f = s[W-1:0]; c = s[W];
        v = (a[W-1] != b[W-1]) && (f[W-1] != a[W-1]);
      end
      FS_AND:  f = a & b;
      FS_OR:   f = a | b;
      FS_XOR:  f = a ^ b;
      FS_NOT:  f = ~a;
      FS_SHL:  f = a << sh;
      FS_SHR:  f = a >> sh;
      default: f = '0;
    endcase
    return {(f == '0), c, f[W-1], v, f};
  endfunction

  always_comb {d1_fu_z, d1_fu_c, d1_fu_n, d1_fu_v, d1_fu_f} = fu_eval(d1_fu_a, d1_fu_b, d1_fu_sh, d1_fu_fs);
  always_comb {d3_fu_z, d3_fu_c, d3_fu_n, d3_fu_v, d3_fu_f} = fu_eval(d3_fu_a, d3_fu_b, d3_fu_sh, d3_fu_fs);

  fu_request_arbiter #(.DATA_W(W), .SETTLE_CYCLES(1)) dut1 (
    .CLK(CLK), .RESET(RESET), .req_valid(d1_req_valid), .req_ready(d1_req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_sh(req0_sh), .req0_fs(req0_fs),
    .req1_a(req1_a), .req1_b(req1_b), .req1_sh(req1_sh), .req1_fs(req1_fs),
    .fu_reset(d1_fu_reset), .fu_a(d1_fu_a), .fu_b(d1_fu_b), .fu_sh(d1_fu_sh), .fu_fs(d1_fu_fs),
    .fu_f(d1_fu_f), .fu_z(d1_fu_z), .fu_c(d1_fu_c), .fu_n(d1_fu_n), .fu_v(d1_fu_v),
    .rsp_valid(d1_rsp_valid), .rsp_ready(d1_rsp_ready), .rsp_id(d1_rsp_id),
    .rsp_f(d1_rsp_f), .rsp_flags(d1_rsp_flags), .rsp_err(d1_rsp_err)
  );

  fu_request_arbiter #(.DATA_W(W), .SETTLE_CYCLES(3)) dut3 (
    .CLK(CLK), .RESET(RESET), .req_valid(d3_req_valid), .req_ready(d3_req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_sh(req0_sh), .req0_fs(req0_fs),
    .req1_a(req1_a), .req1_b(req1_b), .req1_sh(req1_sh), .req1_fs(req1_fs),
    .fu_reset(d3_fu_reset), .fu_a(d3_fu_a), .fu_b(d3_fu_b), .fu_sh(d3_fu_sh), .fu_fs(d3_fu_fs),
    .fu_f(d3_fu_f), .fu_z(d3_fu_z), .fu_c(d3_fu_c), .fu_n(d3_fu_n), .fu_v(d3_fu_v),
    .rsp_valid(d3_rsp_valid), .rsp_ready(d3_rsp_ready), .rsp_id(d3_rsp_id),
    .rsp_f(d3_rsp_f), .rsp_flags(d3_rsp_flags), .rsp_err(d3_rsp_err)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic id, input logic [W-1:0] f, input logic [3:0] flags, input logic err);
    exp_t e;
    e.id = id; e.f = f; e.flags = flags; e.err = err;
    sb.push_back(e);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_id"},    rsp_id,    0);
    chk({tag, "_rsp_f"},     rsp_f,     0);
    chk({tag, "_rsp_flags"}, rsp_flags, 0);
    chk({tag, "_rsp_err"},   rsp_err,   0);
    chk({tag, "_fu_a"},      fu_a,      0);
    chk({tag, "_fu_b"},      fu_b,      0);
    chk({tag, "_fu_sh"},     fu_sh,     0);
    chk({tag, "_fu_fs"},     fu_fs,     0);
    chk({tag, "_fu_reset"},  fu_reset,  RESET);
  endtask

  // Called at a negedge: drive port p, wait (bounded) for ready, let the
  // accept edge pass, then drop valid. Returns at the negedge after accept.
  task automatic send(input logic p, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [4:0] sh, input logic [4:0] fs);
    int n = 0;
    if (!p) begin req0_a = a; req0_b = b; req0_sh = sh; req0_fs = fs; end
    else    begin req1_a = a; req1_b = b; req1_sh = sh; req1_fs = fs; end
    req_valid[p] = 1'b1;
    #1;
    while (!req_ready[p] && n < 50) begin
      @(negedge CLK); #1; n++;
    end
    chk("accept", req_ready[p], 1);
    @(negedge CLK);
    req_valid[p] = 1'b0;
  endtask

  // Called at the negedge after accept (cycle t+1). Measures latency,
  // optionally stalls rsp_ready for 'hold' cycles, then consumes.
  task automatic await_rsp(input int exp_lat, input int hold);
    int   lat = 1;
    exp_t e;
    while (!rsp_valid && lat < 60) begin
      @(negedge CLK); lat++;
    end
    chk("rsp_valid", rsp_valid, 1);
    chk("latency", lat, exp_lat);
    if (sb.size() > 0) e = sb.pop_front();
    else e = '{id: 1'bx, f: 'x, flags: 'x, err: 1'bx};
    repeat (hold) begin
      chk("hold_valid", rsp_valid, 1);
      chk("hold_f", rsp_f, e.f);
      chk("hold_req_ready", req_ready, 0);
      @(negedge CLK);
    end
    chk("rsp_id", rsp_id, e.id);
    chk("rsp_f", rsp_f, e.f);
    chk("rsp_flags", rsp_flags, e.flags);
    chk("rsp_err", rsp_err, e.err);
    rsp_ready = 1'b1;
    @(negedge CLK);
    rsp_ready = 1'b0;
    chk("rsp_drop", rsp_valid, 0);
  endtask

  initial begin
    // Reset
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    chk_reset_outputs("reset");
    RESET = 1'b0;
    @(negedge CLK);

    // 1. Port 0 ADD 5+3
    push(1'b0, 32'd8, 4'b0000, 1'b0);
    send(1'b0, 32'd5, 32'd3, 5'd0, FS_ADD);
    await_rsp(2, 0);

    // 2. Both ports valid right after reset
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    req0_a = 32'd10;  req0_b = 32'd4;  req0_sh = 5'd0; req0_fs = FS_SUB;
    req1_a = 32'hF0;  req1_b = 32'h3C; req1_sh = 5'd0; req1_fs = FS_AND;
    req_valid = 2'b11;
    #1;
    chk("tie_grant", req_ready, 2'b01);
    push(1'b0, 32'd6, 4'b0100, 1'b0);
    @(negedge CLK);
    req_valid[0] = 1'b0;
    chk("settle_ready_low", req_ready, 0);
    await_rsp(2, 0);
    push(1'b1, 32'h30, 4'b0000, 1'b0);
    send(1'b1, 32'hF0, 32'h3C, 5'd0, FS_AND);
    await_rsp(2, 0);
    req_valid = 2'b11;
    #1;
    chk("prio_back_to_0", req_ready, 2'b01);
    req_valid = 2'b00;
    @(negedge CLK);

    // 3. Illegal FS on port 1
    push(1'b1, 32'd0, 4'b0000, 1'b1);
    send(1'b1, 32'h11, 32'h22, 5'd0, 5'b00011);
    await_rsp(1, 0);
    chk("illegal_fu_fs", fu_fs, FS_AND);
    chk("illegal_fu_a", fu_a, 32'hF0);

    // 4. SHL with stalled consumer while port 1 keeps requesting
    req1_a = 32'd7; req1_b = 32'd9; req1_sh = 5'd0; req1_fs = FS_ADD;
    req_valid[1] = 1'b1;
    push(1'b0, 32'd16, 4'b0000, 1'b0);
    send(1'b0, 32'd1, 32'd0, 5'd4, FS_SHL);
    await_rsp(2, 5);
    push(1'b1, 32'h10, 4'b0000, 1'b0);
    send(1'b1, 32'd7, 32'd9, 5'd0, FS_ADD);
    await_rsp(2, 0);

    // 5. Reset during SETTLE drops the operation
    send(1'b0, 32'd7, 32'd7, 5'd0, FS_ADD);
    RESET = 1'b1;
    @(negedge CLK);
    chk_reset_outputs("mid_reset");
    RESET = 1'b0;
    @(negedge CLK);
    chk("no_rsp_after_reset", rsp_valid, 0);
    push(1'b0, 32'd2, 4'b0000, 1'b0);
    send(1'b0, 32'd1, 32'd1, 5'd0, FS_ADD);
    await_rsp(2, 0);

    // 6. SETTLE_CYCLES=3 instance: latency and alternating grants
    sel = 1'b1;
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    chk_reset_outputs("s3_reset");
    RESET = 1'b0;
    @(negedge CLK);
    push(1'b0, 32'd5, 4'b0000, 1'b0);
    send(1'b0, 32'd2, 32'd3, 5'd0, FS_ADD);
    await_rsp(4, 0);
    req0_a = 32'd2;  req0_b = 32'd3;  req0_sh = 5'd0; req0_fs = FS_ADD;
    req1_a = 32'd10; req1_b = 32'd20; req1_sh = 5'd0; req1_fs = FS_ADD;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (k % 2 == 0) begin
        chk("alt_grant", req_ready, 2'b10);
        push(1'b1, 32'd30, 4'b0000, 1'b0);
      end else begin
        chk("alt_grant", req_ready, 2'b01);
        push(1'b0, 32'd5, 4'b0000, 1'b0);
      end
      @(negedge CLK);
      await_rsp(4, 0);
    end
    req_valid = 2'b00;
    @(negedge CLK);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
